// File: rtl/fix_ram_cpu_if_if.sv
// 68k-side bus bundle for the fix RAM CPU port.
// master: the CPU/bus side driving the cycle; slave: the access controller.
interface fix_ram_cpu_if_if #(
  parameter int ADDR_W = 11
);
  logic              nFIXRAM_CS;
  logic              nLDS;
  logic              nUDS;
  logic              M68K_RW;
  logic [ADDR_W-1:0] M68K_ADDR;
  logic [7:0]        M68K_DATA;
  logic [7:0]        M68K_DATA_OUT;
  logic              nDTACK;

  modport master (
    output nFIXRAM_CS, nLDS, nUDS, M68K_RW, M68K_ADDR, M68K_DATA,
    input  M68K_DATA_OUT, nDTACK
  );

  modport slave (
    input  nFIXRAM_CS, nLDS, nUDS, M68K_RW, M68K_ADDR, M68K_DATA,
    output M68K_DATA_OUT, nDTACK
  );
endinterface

// File: rtl/fix_ram_cpu_if.sv
// Fix (text layer) tile RAM access controller, 68k side.
// Captures a CPU bus cycle, waits for the video-granted CPU slot, performs a
// single RAM write or read in that slot and acknowledges with nDTACK until the
// CPU drops chip select. Owns the RAM address / write-enable mux; outside the
// granted slot the RAM address follows the renderer's VIDEO_ADDR.
//
// Optional feature macro: FIX_RAM_READBACK_EN
//   defined   : reads fetch real data through WAIT -> READ -> DONE.
//   undefined : reads skip the RAM and return 8'hFF (IDLE -> DONE).
//
// state | meaning
// IDLE  | no bus cycle in progress, waiting for CS and a data strobe
// WAIT  | cycle captured, waiting for CPU_SLOT (or abort on CS release)
// READ  | RAM read issued in the slot, capturing FIX_RAM_DOUT
// DONE  | access complete, nDTACK low until CS is released
module fix_ram_cpu_if #(
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  fix_ram_cpu_if_if.slave   cpu,
  input  logic              CPU_SLOT,
  input  logic [ADDR_W-1:0] VIDEO_ADDR,
  output logic [ADDR_W-1:0] FIX_RAM_ADDR,
  output logic [7:0]        FIX_RAM_DIN,
  output logic              FIX_RAM_WE,
  input  logic [7:0]        FIX_RAM_DOUT,
  output logic              BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
`ifdef FIX_RAM_READBACK_EN
  localparam logic [1:0] S_READ = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [7:0]        data_q,    data_d;
  logic              rw_q,      rw_d;
  logic              lds_n_q,   lds_n_d;
  logic [7:0]        dout_q,    dout_d;
  logic              dtack_n_q, dtack_n_d;
  logic              grant;

`ifndef FIX_RAM_READBACK_EN
  // RAM read data has no consumer when read-back is compiled out.
  logic unused_dout;
  assign unused_dout = ^FIX_RAM_DOUT;
`endif

  // The CPU owns the RAM port only in WAIT, with CS still held, during the
  // slot strobe; reset in that cycle withdraws ownership so no write leaks.
  always_comb begin
    grant = (state_q == S_WAIT) && !cpu.nFIXRAM_CS && CPU_SLOT && !RESET;
  end

  // Next-state, capture latches and registered acknowledge / read data.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    lds_n_d   = lds_n_q;
    dout_d    = dout_q;
    dtack_n_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!cpu.nFIXRAM_CS && (!cpu.nLDS || !cpu.nUDS)) begin
          addr_d  = cpu.M68K_ADDR;
          data_d  = cpu.M68K_DATA;
          rw_d    = cpu.M68K_RW;
          lds_n_d = cpu.nLDS;
`ifdef FIX_RAM_READBACK_EN
          state_d = S_WAIT;
`else
          // Without read-back a read is answered at once with open-bus data;
          // nDTACK follows one edge later from DONE.
          if (cpu.M68K_RW) begin
            state_d = S_DONE;
            dout_d  = 8'hFF;
          end else begin
            state_d = S_WAIT;
          end
`endif
        end
      end
      S_WAIT: begin
        if (cpu.nFIXRAM_CS) begin
          state_d = S_IDLE;
        end else if (CPU_SLOT) begin
`ifdef FIX_RAM_READBACK_EN
          if (rw_q) begin
            state_d = S_READ;
          end else begin
            state_d   = S_DONE;
            dtack_n_d = 1'b0;
          end
`else
          state_d   = S_DONE;
          dtack_n_d = 1'b0;
`endif
        end
      end
`ifdef FIX_RAM_READBACK_EN
      S_READ: begin
        dout_d    = FIX_RAM_DOUT;
        state_d   = S_DONE;
        dtack_n_d = 1'b0;
      end
`endif
      S_DONE: begin
        if (cpu.nFIXRAM_CS) begin
          state_d = S_IDLE;
        end else begin
          dtack_n_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= 8'h00;
      rw_q      <= 1'b0;
      lds_n_q   <= 1'b1;
      dout_q    <= 8'h00;
      dtack_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      lds_n_q   <= lds_n_d;
      dout_q    <= dout_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  // RAM port mux and status outputs; an upper-byte-only write is acked but
  // never reaches the byte-wide fix RAM.
  always_comb begin
    FIX_RAM_ADDR      = grant ? addr_q : VIDEO_ADDR;
    FIX_RAM_WE        = grant && !rw_q && !lds_n_q;
    FIX_RAM_DIN       = data_q;
    BUSY              = (state_q != S_IDLE);
    cpu.nDTACK        = dtack_n_q;
    cpu.M68K_DATA_OUT = dout_q;
  end

endmodule

// File: tb/tb_fix_ram_cpu_if.sv
// Self-checking bench for fix_ram_cpu_if: directed bus cycles against a
// transaction-level model, a synchronous fix RAM model, and literal checks.
module tb_fix_ram_cpu_if;
  localparam int AW = 11;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CPU_SLOT;
  logic [AW-1:0] VIDEO_ADDR;
  logic [AW-1:0] FIX_RAM_ADDR;
  logic [7:0]    FIX_RAM_DIN;
  logic          FIX_RAM_WE;
  logic [7:0]    FIX_RAM_DOUT;
  logic          BUSY;

  fix_ram_cpu_if_if #(.ADDR_W(AW)) bus ();

  fix_ram_cpu_if #(.ADDR_W(AW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .cpu          (bus.slave),
    .CPU_SLOT     (CPU_SLOT),
    .VIDEO_ADDR   (VIDEO_ADDR),
    .FIX_RAM_ADDR (FIX_RAM_ADDR),
    .FIX_RAM_DIN  (FIX_RAM_DIN),
    .FIX_RAM_WE   (FIX_RAM_WE),
    .FIX_RAM_DOUT (FIX_RAM_DOUT),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  // Synchronous fix RAM, 1-CLK read latency, preloaded with a known pattern.
  logic [7:0] ram [0:2047];
  bit         ram_loaded = 1'b0;
  always @(posedge CLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 8'(i * 7 + 3);
      ram_loaded <= 1'b1;
    end else if (FIX_RAM_WE) begin
      ram[FIX_RAM_ADDR] <= FIX_RAM_DIN;
    end
    FIX_RAM_DOUT <= ram[FIX_RAM_ADDR];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int we_cnt = 0, own_cnt = 0, own_cyc = -1;
  int fall_cyc = -1, rise_cyc = -1;
  int req_cyc = 0, rel_cyc = 0;
  bit slot_auto = 1'b1, slot_man = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a captured request is pending until a slot with CS held; a write
  // is acked on the slot edge, a read one edge later with the RAM byte.
  logic [7:0]    m_ram [0:2047];
  bit            m_pend, m_fetch, m_ack, m_soon;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data, m_dout;
  bit            m_rw, m_lds_n;
  bit            prev_dtack;

  initial begin : compare
    bit            grant;
    logic [AW-1:0] exp_addr;
    bit            exp_we;
    for (int i = 0; i < 2048; i++) m_ram[i] = 8'(i * 7 + 3);
    m_pend = 0; m_fetch = 0; m_ack = 0; m_soon = 0;
    m_addr = '0; m_data = 0; m_dout = 0; m_rw = 0; m_lds_n = 1;
    prev_dtack = 1;
    forever begin
      @(negedge CLK); #2;
      grant    = m_pend && !bus.nFIXRAM_CS && CPU_SLOT && !RESET;
      exp_addr = grant ? m_addr : VIDEO_ADDR;
      exp_we   = grant && !m_rw && !m_lds_n;
      chk("ram_addr", 32'(FIX_RAM_ADDR), 32'(exp_addr));
      chk("ram_we", 32'(FIX_RAM_WE), 32'(exp_we));
      if (grant) chk("ram_din", 32'(FIX_RAM_DIN), 32'(m_data));
      if (FIX_RAM_WE === 1'b1) we_cnt++;
      if (FIX_RAM_ADDR !== VIDEO_ADDR) begin own_cnt++; own_cyc = cyc; end

      if (RESET) begin
        m_pend = 0; m_fetch = 0; m_ack = 0; m_soon = 0; m_dout = 8'h00;
      end else if (m_pend) begin
        if (bus.nFIXRAM_CS) m_pend = 0;
        else if (CPU_SLOT) begin
          m_pend = 0;
          if (m_rw) m_fetch = 1;
          else begin
            m_ack = 1;
            if (!m_lds_n) m_ram[m_addr] = m_data;
          end
        end
      end else if (m_fetch) begin
        m_fetch = 0; m_ack = 1; m_dout = m_ram[m_addr];
      end else if (m_soon) begin
        m_soon = 0;
        if (!bus.nFIXRAM_CS) m_ack = 1;
      end else if (m_ack) begin
        if (bus.nFIXRAM_CS) m_ack = 0;
      end else if (!bus.nFIXRAM_CS && (!bus.nLDS || !bus.nUDS)) begin
        m_addr = bus.M68K_ADDR; m_data = bus.M68K_DATA;
        m_rw = bus.M68K_RW; m_lds_n = bus.nLDS;
`ifdef FIX_RAM_READBACK_EN
        m_pend = 1;
`else
        if (bus.M68K_RW) begin m_soon = 1; m_dout = 8'hFF; end
        else m_pend = 1;
`endif
      end

      @(posedge CLK); #1;
      chk("ndtack", 32'(bus.nDTACK), 32'(!m_ack));
      chk("busy", 32'(BUSY), 32'(m_pend || m_fetch || m_ack || m_soon));
      chk("data_out", 32'(bus.M68K_DATA_OUT), 32'(m_dout));
      if (prev_dtack && bus.nDTACK === 1'b0) fall_cyc = cyc;
      if (!prev_dtack && bus.nDTACK === 1'b1) rise_cyc = cyc;
      prev_dtack = (bus.nDTACK !== 1'b0);
    end
  end

  task automatic tick();
    @(negedge CLK);
    cyc++;
    VIDEO_ADDR = {1'b1, cyc[9:0]};
    CPU_SLOT   = slot_auto ? (cyc[2:0] == 3'd0) : slot_man;
  endtask

  task automatic bus_req(input logic [AW-1:0] a, input logic [7:0] d,
                         input logic rw, input logic lds_n, input logic uds_n);
    tick();
    bus.nFIXRAM_CS = 1'b0; bus.M68K_ADDR = a; bus.M68K_DATA = d;
    bus.M68K_RW = rw; bus.nLDS = lds_n; bus.nUDS = uds_n;
    req_cyc = cyc;
  endtask

  task automatic bus_rel();
    tick();
    bus.nFIXRAM_CS = 1'b1; bus.nLDS = 1'b1; bus.nUDS = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (bus.nDTACK !== 1'b0 && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      n_vec++; n_err++;
      $display("FAIL %s: nDTACK timeout got 1 expected 0", nm);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int we0, own0;
    RESET = 1'b1; CPU_SLOT = 1'b0; VIDEO_ADDR = 11'h400;
    bus.nFIXRAM_CS = 1'b1; bus.nLDS = 1'b1; bus.nUDS = 1'b1;
    bus.M68K_RW = 1'b1; bus.M68K_ADDR = '0; bus.M68K_DATA = 8'h00;
    repeat (3) tick();
    chk("rst_ndtack", 32'(bus.nDTACK), 32'd1);
    chk("rst_dout", 32'(bus.M68K_DATA_OUT), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_we", 32'(FIX_RAM_WE), 32'd0);
    RESET = 1'b0;
    tick();

    // Low-byte write with periodic slots.
    we0 = we_cnt; own0 = own_cnt;
    bus_req(11'h123, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_ack("wr");
    chk("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("wr_owned_cycles", 32'(own_cnt - own0), 32'd1);
    chk("wr_dtack_latency", 32'(fall_cyc), 32'(own_cyc));
    chk("wr_ram_byte", 32'(ram[11'h123]), 32'h5A);
    repeat (12) tick();
    chk("wr_no_retrigger", 32'(we_cnt - we0), 32'd1);
    chk("wr_held_busy", 32'(BUSY), 32'd1);
    bus_rel();
    tick();
    chk("wr_release", 32'(rise_cyc), 32'(rel_cyc));
    tick();

    // Read back.
    own0 = own_cnt;
    bus_req(11'h123, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_ack("rd");
`ifdef FIX_RAM_READBACK_EN
    chk("rd_data", 32'(bus.M68K_DATA_OUT), 32'h5A);
    chk("rd_dtack_latency", 32'(fall_cyc), 32'(own_cyc + 1));
`else
    chk("rd_data", 32'(bus.M68K_DATA_OUT), 32'hFF);
    chk("rd_dtack_latency", 32'(fall_cyc), 32'(req_cyc + 1));
    chk("rd_no_ram_access", 32'(own_cnt - own0), 32'd0);
`endif
    bus_rel();
    repeat (2) tick();

    // Upper-byte-only write: acked, RAM untouched.
    we0 = we_cnt;
    bus_req(11'h0AA, 8'hC3, 1'b0, 1'b1, 1'b0);
    wait_ack("uds");
    chk("uds_ndtack", 32'(bus.nDTACK), 32'd0);
    chk("uds_no_we", 32'(we_cnt - we0), 32'd0);
    chk("uds_ram_kept", 32'(ram[11'h0AA]), 32'hA9);
    bus_rel();
    repeat (2) tick();

    // Abort in WAIT before any slot, then a normal write.
    slot_auto = 1'b0; slot_man = 1'b0;
    we0 = we_cnt;
    bus_req(11'h055, 8'h33, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("abort_busy_wait", 32'(BUSY), 32'd1);
    bus_rel();
    repeat (2) tick();
    chk("abort_idle", 32'(BUSY), 32'd0);
    chk("abort_ndtack", 32'(bus.nDTACK), 32'd1);
    chk("abort_no_we", 32'(we_cnt - we0), 32'd0);
    chk("abort_ram_kept", 32'(ram[11'h055]), 32'h56);
    slot_auto = 1'b1;
    bus_req(11'h055, 8'h77, 1'b0, 1'b0, 1'b1);
    wait_ack("after_abort");
    chk("after_abort_ram", 32'(ram[11'h055]), 32'h77);
    bus_rel();
    repeat (2) tick();

    // Reset in the slot cycle of a pending write.
    slot_auto = 1'b0; slot_man = 1'b0;
    we0 = we_cnt;
    bus_req(11'h066, 8'h99, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    slot_man = 1'b1;
    tick();
    RESET = 1'b1;
    slot_man = 1'b0;
    tick();
    chk("rst_mid_no_we", 32'(we_cnt - we0), 32'd0);
    chk("rst_mid_ndtack", 32'(bus.nDTACK), 32'd1);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_ram_kept", 32'(ram[11'h066]), 32'hCD);
    bus_rel();
    RESET = 1'b0;
    slot_auto = 1'b1;
    tick();

    // Another write with video traffic running.
    we0 = we_cnt; own0 = own_cnt;
    bus_req(11'h3FF, 8'hE1, 1'b0, 1'b0, 1'b0);
    wait_ack("wr2");
    chk("wr2_ram", 32'(ram[11'h3FF]), 32'hE1);
    chk("wr2_owned_cycles", 32'(own_cnt - own0), 32'd1);
    bus_rel();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
